// File: rtl/oam_dma_if.sv
// CPU/memory-map bus bundle seen by the OAM DMA engine.
// slave = DMA engine side, master = CPU / external bus-mux side.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_r_nw;
    logic [7:0]  mem_data_in;
    logic        dma_active;
    logic        cpu_rdy;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_r_nw;

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_r_nw, mem_data_in,
        output dma_active, cpu_rdy, dma_addr, dma_data_out, dma_r_nw
    );

    modport master (
        output cpu_addr, cpu_data_out, cpu_r_nw, mem_data_in,
        input  dma_active, cpu_rdy, dma_addr, dma_data_out, dma_r_nw
    );
endinterface

// File: rtl/oam_dma.sv
// OAM sprite DMA: a CPU write to 16'h4014 copies 256 bytes from page:00..page:FF to 16'h2004.
// Optional macro OAM_DMA_ALIGN_EN adds a parity-driven ALIGN dummy cycle after HALT.
//
// state | meaning
// IDLE  | bus owned by CPU, waiting for a write to 16'h4014
// HALT  | CPU stalled, dummy read of 16'h0000
// ALIGN | extra dummy read so READ starts on the right bus phase
// READ  | read {page,idx}, capture byte into buffer
// WRITE | write buffer to 16'h2004, advance idx
module oam_dma (
    input  logic      clk_ph1,
    input  logic      rst,
    oam_dma_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_buffer;
    logic        w_trigger;
    logic [15:0] w_addr;
    logic        w_r_nw;

    // Only looked at in IDLE, so writes to 16'h4014 during a transfer are ignored.
    assign w_trigger = (r_state == S_IDLE) && (bus.cpu_addr == 16'h4014) && !bus.cpu_r_nw;

`ifdef OAM_DMA_ALIGN_EN
    logic r_parity;

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) r_parity <= 1'b0;
        else      r_parity <= ~r_parity;
    end
`endif

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next = S_HALT;
`ifdef OAM_DMA_ALIGN_EN
            S_HALT:  w_next = r_parity ? S_ALIGN : S_READ;
`else
            S_HALT:  w_next = S_READ;
`endif
            S_ALIGN: w_next = S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_buffer <= 8'h00;
        end else begin
            if (w_trigger) begin
                r_page <= bus.cpu_data_out;
                r_idx  <= 8'h00;
            end
            if (r_state == S_READ)  r_buffer <= bus.mem_data_in;
            // 8-bit wrap keeps the address inside the selected page.
            if (r_state == S_WRITE) r_idx <= r_idx + 8'h01;
        end
    end

    always_comb begin
        w_addr = 16'h0000;
        w_r_nw = 1'b1;
        case (r_state)
            S_READ:  w_addr = {r_page, r_idx};
            S_WRITE: begin
                w_addr = 16'h2004;
                w_r_nw = 1'b0;
            end
            default: begin
                w_addr = 16'h0000;
                w_r_nw = 1'b1;
            end
        endcase
    end

    assign bus.dma_addr     = w_addr;
    assign bus.dma_r_nw     = w_r_nw;
    assign bus.dma_data_out = r_buffer;
    assign bus.dma_active   = (r_state != S_IDLE);
    assign bus.cpu_rdy      = (r_state == S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: trigger decode table plus full-transfer, alignment and reset sequences.
module tb_oam_dma;

    logic clk_ph1;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic tb_par;

    oam_dma_if bus ();

    oam_dma dut (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Reference parity: toggles every cycle from reset release.
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a[7:0] + 8'h3C) ^ {a[14:8], a[15]};
    endfunction

    assign bus.mem_data_in = mem_f(bus.dma_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cpu_idle();
        bus.cpu_addr     = 16'h0000;
        bus.cpu_r_nw     = 1'b1;
        bus.cpu_data_out = 8'h00;
    endtask

    task automatic cpu_drive(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        bus.cpu_addr     = a;
        bus.cpu_r_nw     = rnw;
        bus.cpu_data_out = d;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [7:0] exp_data);
        chk({tag, "_active"}, {31'd0, bus.dma_active}, 32'd0);
        chk({tag, "_rdy"},    {31'd0, bus.cpu_rdy},    32'd1);
        chk({tag, "_addr"},   {16'd0, bus.dma_addr},   32'h0000);
        chk({tag, "_rnw"},    {31'd0, bus.dma_r_nw},   32'd1);
        chk({tag, "_data"},   {24'd0, bus.dma_data_out}, {24'd0, exp_data});
    endtask

    // Write to 16'h4014 on one cycle; returns at the negedge of the HALT cycle.
    task automatic trigger(input logic [7:0] page);
        @(negedge clk_ph1);
        cpu_drive(16'h4014, 1'b0, page);
        @(negedge clk_ph1);
        cpu_idle();
    endtask

    // HALT parity equals the inverse of tb_par at the negedge where the write is driven.
    task automatic trigger_par(input logic [7:0] page, input logic want);
        @(negedge clk_ph1);
        if (tb_par == want) @(negedge clk_ph1);
        cpu_drive(16'h4014, 1'b0, page);
        @(negedge clk_ph1);
        cpu_idle();
    endtask

    // Called at the negedge of the HALT cycle; checks every bus cycle through the return to IDLE.
    task automatic run_transfer(input logic [7:0] page, input int inject_c, input int stop_idx);
        int          a;
        int          total;
        int          k;
        int          i;
        logic [15:0] ea;
        logic        ernw;
        logic        eact;
        a = 0;
`ifdef OAM_DMA_ALIGN_EN
        a = tb_par ? 1 : 0;
`endif
        total = 513 + a;
        for (int c = 0; c <= total; c++) begin
            if (c > 0) @(negedge clk_ph1);
            if (c == inject_c + 1) cpu_idle();
            i = 0;
            ernw = 1'b1;
            eact = 1'b1;
            ea = 16'h0000;
            if (c == total) begin
                eact = 1'b0;
            end else if (c >= 1 + a) begin
                k = c - 1 - a;
                i = k / 2;
                if (k % 2 == 0) begin
                    ea = {page, i[7:0]};
                end else begin
                    ea = 16'h2004;
                    ernw = 1'b0;
                end
            end
            chk("active", {31'd0, bus.dma_active}, {31'd0, eact});
            chk("rdy",    {31'd0, bus.cpu_rdy},    {31'd0, ~eact});
            chk("addr",   {16'd0, bus.dma_addr},   {16'd0, ea});
            chk("rnw",    {31'd0, bus.dma_r_nw},   {31'd0, ernw});
            if (!ernw)
                chk("wdata", {24'd0, bus.dma_data_out}, {24'd0, mem_f({page, i[7:0]})});
            if (c == total)
                chk("hold_data", {24'd0, bus.dma_data_out}, {24'd0, mem_f({page, 8'hFF})});
            if (c == inject_c) cpu_drive(16'h4014, 1'b0, 8'h77);
            if (stop_idx >= 0 && !ernw && i == stop_idx) return;
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        r_nw;
        logic [7:0]  data;
        logic        exp_trig;
        int          inject_c;
    } vec_t;

    vec_t vecs [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        cpu_idle();

        vecs[0] = '{16'h4015, 1'b0, 8'h02, 1'b0, -5};
        vecs[1] = '{16'h4014, 1'b1, 8'h02, 1'b0, -5};
        vecs[2] = '{16'h0014, 1'b0, 8'h02, 1'b0, -5};
        vecs[3] = '{16'h4014, 1'b0, 8'h02, 1'b1, 101};
        vecs[4] = '{16'hC014, 1'b0, 8'h13, 1'b0, -5};
        vecs[5] = '{16'h4014, 1'b0, 8'hFF, 1'b1, -5};

        #12;
        chk_idle_outputs("reset", 8'h00);
        @(negedge clk_ph1);
        rst = 1'b1;
        @(negedge clk_ph1);
        chk_idle_outputs("post_reset", 8'h00);

        for (int v = 0; v < 6; v++) begin
            @(negedge clk_ph1);
            cpu_drive(vecs[v].addr, vecs[v].r_nw, vecs[v].data);
            @(negedge clk_ph1);
            cpu_idle();
            chk($sformatf("vec%0d_trig", v), {31'd0, bus.dma_active}, {31'd0, vecs[v].exp_trig});
            if (vecs[v].exp_trig) run_transfer(vecs[v].data, vecs[v].inject_c, -1);
        end

        // HALT with parity 1, then parity 0 (lengths differ only with alignment enabled).
        trigger_par(8'h45, 1'b1);
        chk("par1_halt", {31'd0, tb_par}, 32'd1);
        run_transfer(8'h45, -5, -1);
        trigger_par(8'h46, 1'b0);
        chk("par0_halt", {31'd0, tb_par}, 32'd0);
        run_transfer(8'h46, -5, -1);

        // Reset during the WRITE of idx 8'h0A aborts immediately; next trigger starts from idx 0.
        trigger(8'h33);
        run_transfer(8'h33, -5, 10);
        rst = 1'b0;
        #1;
        chk_idle_outputs("abort", 8'h00);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_ph1);
            chk("abort_no_write", {31'd0, bus.dma_r_nw}, 32'd1);
            chk("abort_inactive", {31'd0, bus.dma_active}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk_ph1);
        chk_idle_outputs("after_abort", 8'h00);
        trigger(8'h33);
        run_transfer(8'h33, -5, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
